// File: rtl/game_timer_bcd.sv
// Game elapsed-time counter in 3-digit BCD with best-time capture for the end screen.
// All outputs are registered; the one-second tick comes from an internal prescaler.
module game_timer_bcd #(
   parameter int unsigned TICK_DIV = 100000000,
   parameter logic [11:0] MAX_BCD  = 12'h999
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        finish,
   input  logic        clear_best,
   output logic [11:0] time_bcd,
   output logic [11:0] best_bcd,
   output logic        best_valid,
   output logic        new_best,
   output logic        running,
   output logic        end_screen
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [11:0]   time_q, time_d;
   logic [11:0]   best_q, best_d;
   logic          best_valid_q, best_valid_d;
   logic          new_best_q, new_best_d;
   logic          running_q, end_screen_q;
   logic          tick;

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (r[3:0] == 4'd9) begin
         r[3:0] = 4'd0;
         if (r[7:4] == 4'd9) begin
            r[7:4] = 4'd0;
            if (r[11:8] == 4'd9) r[11:8] = 4'd0;
            else                 r[11:8] = r[11:8] + 4'd1;
         end else begin
            r[7:4] = r[7:4] + 4'd1;
         end
      end else begin
         r[3:0] = r[3:0] + 4'd1;
      end
      return r;
   endfunction

   assign tick = (state_q == StRun) && (presc_q == PresLast);

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         presc_q      <= '0;
         time_q       <= '0;
         best_q       <= '0;
         best_valid_q <= 1'b0;
         new_best_q   <= 1'b0;
         running_q    <= 1'b0;
         end_screen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         time_q       <= time_d;
         best_q       <= best_d;
         best_valid_q <= best_valid_d;
         new_best_q   <= new_best_d;
         running_q    <= (state_d == StRun);
         end_screen_q <= (state_d == StDone);
      end
   end

   // Next-state logic; finish takes priority over start while running
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start)  state_d = StRun;
         StRun:   if (finish) state_d = StDone;
         StDone:  if (start)  state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next values
   always_comb begin
      presc_d      = presc_q;
      time_d       = time_q;
      best_d       = best_q;
      best_valid_d = best_valid_q;
      new_best_d   = new_best_q;
      unique case (state_q)
         StIdle: begin
            presc_d = '0;
            time_d  = '0;
         end
         StRun: begin
            if (finish) begin
               // Tick in the finish cycle is dropped; time stays frozen
               presc_d = '0;
               if (!best_valid_q || (time_q < best_q)) begin
                  best_d       = time_q;
                  best_valid_d = 1'b1;
                  new_best_d   = 1'b1;
               end else begin
                  new_best_d = 1'b0;
               end
            end else if (start) begin
               presc_d = '0;
               time_d  = '0;
            end else begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (tick && (time_q != MAX_BCD)) time_d = bcd_inc(time_q);
            end
         end
         StDone: begin
            if (start) begin
               presc_d    = '0;
               time_d     = '0;
               new_best_d = 1'b0;
            end
         end
         default: begin
            presc_d = '0;
            time_d  = '0;
         end
      endcase
      if (clear_best) begin
         best_d       = '0;
         best_valid_d = 1'b0;
         new_best_d   = 1'b0;
      end
   end

   assign time_bcd   = time_q;
   assign best_bcd   = best_q;
   assign best_valid = best_valid_q;
   assign new_best   = new_best_q;
   assign running    = running_q;
   assign end_screen = end_screen_q;

endmodule

// File: doc/game_timer_bcd.md
Name: game_timer_bcd

Overview:
- Sequential timekeeping stage directly upstream of the game-end screen renderer.
- Measures elapsed game time in whole seconds, freezes it when the game ends, and tracks the best (lowest) completed time.
- Presents both times as registered 3-digit BCD values, plus status flags, for the end-screen pixel logic to draw the "TIME TAKEN" and "BEST TIME" digits.
- Runs in the system clock domain alongside the OLED pixel pipeline.

Parameters:
- TICK_DIV, 100000000: clock cycles per one-second tick. Legal range 2..2^27-1; benches override it with a small value.
- MAX_BCD, 12'h999: saturation value of the elapsed-time counter, in BCD.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- start  in  1  one-cycle pulse: begin a new game run
- finish  in  1  one-cycle pulse: game completed
- clear_best  in  1  one-cycle pulse: forget the stored best time
- time_bcd  out  12  elapsed seconds: [11:8] hundreds, [7:4] tens, [3:0] ones
- best_bcd  out  12  best completed time, same digit layout
- best_valid  out  1  high once best_bcd holds a real result
- new_best  out  1  high in DONE if the last finish set a new best
- running  out  1  high in RUN
- end_screen  out  1  high in DONE; selects the end screen downstream

Behaviour:
- Reset: synchronous, sampled on the rising edge of clk while rst_n=0. Reset has priority over every other input, including a run in progress. On reset:
  - state = IDLE
  - time_bcd = 0, best_bcd = 0
  - best_valid = 0, new_best = 0, running = 0, end_screen = 0
  - prescaler = 0
- All outputs are registered. Each output reflects an input event on the first clock edge after that event is sampled (latency 1).
- IDLE:
  - time_bcd = 0 and the prescaler is held at 0.
  - start -> RUN. finish is ignored.
- RUN:
  - The prescaler counts 0..TICK_DIV-1. When it reaches TICK_DIV-1 it wraps to 0 and issues a tick.
  - Tick: time_bcd increments as a BCD number. Each digit wraps 9->0 with a carry into the next digit, e.g. 0x099 -> 0x100.
  - At MAX_BCD, further ticks leave time_bcd unchanged (saturate). It does not wrap to 0.
  - finish -> DONE:
    - time_bcd freezes at its current value. A tick in the same cycle as finish is discarded.
    - Best capture: if best_valid=0, or time_bcd < best_bcd by unsigned 12-bit compare (BCD ordering matches numeric ordering), then best_bcd <= time_bcd, best_valid <= 1, new_best <= 1. Otherwise new_best <= 0.
    - A finish at time 0x000 counts as a valid result.
  - start without finish: restart the run. time_bcd <= 0, prescaler <= 0, state stays RUN.
  - start and finish in the same cycle: finish wins; start is ignored.
- DONE:
  - time_bcd, best_bcd and new_best are held.
  - start -> RUN with time_bcd <= 0, prescaler <= 0, new_best <= 0.
  - finish is ignored.
- clear_best, accepted in any state:
  - best_bcd <= 0, best_valid <= 0, new_best <= 0.
  - If it coincides with the finish capture, clear_best wins: best stays invalid, new_best = 0, and state still moves to DONE with time_bcd frozen.
- running = (state==RUN); end_screen = (state==DONE).
- No arithmetic produces non-BCD digit values (A-F) in time_bcd or best_bcd at any time.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high with no stimulus for 50 cycles (TICK_DIV=4) -> all outputs 0 and state stays IDLE.
- First run: TICK_DIV=4, start, wait 40 cycles, finish -> time_bcd=0x010, best_bcd=0x010, best_valid=1, new_best=1, end_screen=1 one cycle after finish.
- Slower run: start, run 15 ticks, finish -> time_bcd=0x015, best_bcd stays 0x010, new_best=0. Then a faster run of 7 ticks -> best_bcd=0x007, new_best=1.
- Digit carry and saturation: TICK_DIV=2, run for 99 ticks -> time_bcd=0x099; next tick -> 0x100. Run to 999 ticks, apply 5 more ticks -> time_bcd stays 0x999.
- Simultaneous events:
  - start and finish together in RUN -> DONE with frozen time.
  - finish on a tick cycle -> the tick is not counted.
  - clear_best together with finish -> best_valid=0, best_bcd=0, end_screen=1.
- Reset mid-run: reset asserted at time_bcd=0x023 with best_bcd=0x010 -> the next edge gives IDLE with every output 0, including best_valid.
